// File: rtl/keypad_pkg.sv
// Shared types and elaboration-time helpers for the keypad scan controller.
// Latency: none (package only).
// Backpressure: not applicable.
package keypad_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    UPDATE = 2'd2,
    EMIT   = 2'd3
  } scan_state_t;

  // Convert a time in ns to clock cycles, never less than one cycle.
  function automatic int cycles_from_ns(input int freq_mhz, input int time_ns);
    int c;
    c = freq_mhz * time_ns / 1000;
    return (c < 1) ? 1 : c;
  endfunction

  // Width of a key index for n keys, at least one bit.
  function automatic int key_code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_key_filter.sv
// Per-key debounce filter: debounced level plus a disagreement counter.
// Latency: state flips on the edge of the DEBOUNCE_SCANS-th consecutive disagreeing sample.
// Backpressure: none; only advances when en_i is high.
module keypad_key_filter #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sample_i,
  output logic state_o,
  output logic flip_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          w_disagree;
  logic          w_at_limit;

  assign w_disagree = (sample_i != r_state);
  assign w_at_limit = (r_cnt == CW'(DEBOUNCE_SCANS - 1));
  assign flip_o     = en_i && w_disagree && w_at_limit;
  assign state_o    = r_state;

  // Count consecutive disagreeing samples; flip the level when the limit is reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else if (en_i) begin
      if (!w_disagree) begin
        r_cnt <= '0;
      end else if (w_at_limit) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Key matrix scanner: drives rows one-cold, debounces each key, emits press (and with
//   KEYPAD_RELEASE_EVT_EN, release) events. Latency: event within one frame of debounce.
// Backpressure: a held event (valid && !ready) stalls scanning in EMIT; nothing is dropped.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter  int CLK_FREQ_MHZ   = 50,
  parameter  int SETTLE_TIME_NS = 2000,
  parameter  int ROWS           = 4,
  parameter  int COLS           = 4,
  parameter  int DEBOUNCE_SCANS = 4,
  localparam int NKEYS          = ROWS * COLS,
  localparam int KW             = key_code_width(NKEYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [ROWS-1:0]  row_o,
  input  logic [COLS-1:0]  col_i,
  output logic [KW-1:0]    key_code_o,
  output logic             key_release_o,
  output logic             key_valid_o,
  input  logic             key_ready_i,
  output logic [NKEYS-1:0] key_state_o
);

  localparam int SETTLE_CYCLES = cycles_from_ns(CLK_FREQ_MHZ, SETTLE_TIME_NS);
  localparam int SCW           = $clog2(SETTLE_CYCLES + 1);
  localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW            = (COLS > 1) ? $clog2(COLS) : 1;

  scan_state_t      r_state, w_state_nxt;
  logic [RW-1:0]    r_row, w_row_nxt;
  logic [CW-1:0]    r_col, w_col_nxt;
  logic [SCW-1:0]   r_settle, w_settle_nxt;
  logic [COLS-1:0]  r_sync1, r_sync2;
  logic [COLS-1:0]  r_cols;
  logic [ROWS-1:0]  r_row_o;
  logic             r_valid;
  logic [KW-1:0]    r_code;

  logic [KW-1:0]    w_key;
  logic             w_sample;
  logic [NKEYS-1:0] w_filt_en;
  logic [NKEYS-1:0] w_flip;
  logic             w_emit_req;
  logic             w_load;
  logic             w_last_col;
  logic             w_advance;

  assign w_key      = KW'(int'(r_row) * COLS + int'(r_col));
  assign w_sample   = r_cols[r_col];
  assign w_filt_en  = (r_state == UPDATE) ? (NKEYS'(1) << w_key) : '0;
  assign w_load     = (r_state == EMIT) && (!r_valid || key_ready_i);
  assign w_last_col = (r_col == CW'(COLS - 1));

`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_emit_req = |w_flip;
`else
  // Release flips only update the debounced level.
  assign w_emit_req = (|w_flip) && w_sample;
`endif

  // One filter per key; only the key under the column cursor is enabled.
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    keypad_key_filter #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_filt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (w_filt_en[i]),
      .sample_i(w_sample),
      .state_o (key_state_o[i]),
      .flip_o  (w_flip[i])
    );
  end

  // Scan sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= DRIVE;
      r_row    <= '0;
      r_col    <= '0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // Next-state logic: settle, sample, walk the columns, stall in EMIT until the slot frees.
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_settle_nxt = r_settle;
    w_advance    = 1'b0;
    case (r_state)
      DRIVE: begin
        if (r_settle == SCW'(SETTLE_CYCLES - 1)) begin
          w_settle_nxt = '0;
          w_state_nxt  = SAMPLE;
        end else begin
          w_settle_nxt = r_settle + SCW'(1);
        end
      end
      SAMPLE: begin
        w_col_nxt   = '0;
        w_state_nxt = UPDATE;
      end
      UPDATE: begin
        if (w_emit_req) w_state_nxt = EMIT;
        else            w_advance   = 1'b1;
      end
      EMIT: begin
        if (w_load) w_advance = 1'b1;
      end
      default: w_state_nxt = DRIVE;
    endcase
    if (w_advance) begin
      if (w_last_col) begin
        w_col_nxt    = '0;
        w_row_nxt    = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        w_settle_nxt = '0;
        w_state_nxt  = DRIVE;
      end else begin
        w_col_nxt   = r_col + CW'(1);
        w_state_nxt = UPDATE;
      end
    end
  end

  // Two-flop column synchronizer, then latch the pressed pattern for the current row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_cols  <= '0;
    end else begin
      r_sync1 <= col_i;
      r_sync2 <= r_sync1;
      if (r_state == SAMPLE) r_cols <= ~r_sync2;
    end
  end

  // Registered one-cold row drive follows the row index; all released during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_row_o <= '1;
    else         r_row_o <= ~(ROWS'(1) << w_row_nxt);
  end

  // Output slot: a load wins over a same-edge handshake clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_code  <= w_key;
    end else if (r_valid && key_ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  logic r_rel;

  // Release flag travels with the code; the latched sample is 0 for a release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_rel <= 1'b0;
    else if (w_load) r_rel <= ~w_sample;
  end

  assign key_release_o = r_rel;
`else
  assign key_release_o = 1'b0;
`endif

  assign row_o       = r_row_o;
  assign key_valid_o = r_valid;
  assign key_code_o  = r_code;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a matrix model drives col_i from row_o, a per-frame
// debounce reference predicts events, and a scoreboard checks every transfer.
module tb_keypad_scan_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NK     = ROWS * COLS;
  localparam int KW     = 4;
  localparam int DEB    = 4;
  localparam int SETTLE = 20;                       // 50 MHz * 400 ns
  localparam int FRAME  = ROWS * (SETTLE + 1 + COLS);
  localparam logic [ROWS-1:0] ROW0 = 4'b1110;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic            clk_i;
  logic            rst_ni;
  logic [ROWS-1:0] row_o;
  logic [COLS-1:0] col_i;
  logic [KW-1:0]   key_code_o;
  logic            key_release_o;
  logic            key_valid_o;
  logic            key_ready_i;
  logic [NK-1:0]   key_state_o;

  keypad_scan_ctrl #(
    .CLK_FREQ_MHZ  (50),
    .SETTLE_TIME_NS(400),
    .ROWS          (ROWS),
    .COLS          (COLS),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .row_o        (row_o),
    .col_i        (col_i),
    .key_code_o   (key_code_o),
    .key_release_o(key_release_o),
    .key_valid_o  (key_valid_o),
    .key_ready_i  (key_ready_i),
    .key_state_o  (key_state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #10 clk_i = ~clk_i;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  logic [NK-1:0] matrix;
  always_comb begin
    col_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_o[r] && matrix[r*COLS+c]) col_i[c] = 1'b0;
  end

  // Reference: keys only change at frame starts, so each key sees one sample per frame.
  logic [NK-1:0] plan;
  int            mode;        // 0 hold plan, 1 random, 2 key 6 toggles each frame
  logic [NK-1:0] m_state;
  int            m_cnt [NK];
  int            q_code [$];
  bit            q_rel  [$];
  int            frame_cnt = 0;
  int            n_xfer    = 0;
  int            last_code = -1;
  int            last_rel  = 0;

  task automatic model_reset();
    m_state = '0;
    for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    q_code.delete();
    q_rel.delete();
  endtask

  task automatic frame_start();
    check("frame_state", 32'(key_state_o), 32'(m_state));
    if (mode == 1)      matrix = NK'($urandom);
    else if (mode == 2) matrix = plan ^ ((frame_cnt % 2 == 1) ? NK'(16'h0040) : NK'(0));
    else                matrix = plan;
    for (int k = 0; k < NK; k++) begin
      if (matrix[k] == m_state[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] == DEB - 1) begin
        m_state[k] = matrix[k];
        m_cnt[k]   = 0;
        if (matrix[k] || REL_EN) begin
          q_code.push_back(k);
          q_rel.push_back(!matrix[k]);
        end
      end else begin
        m_cnt[k]++;
      end
    end
    frame_cnt++;
  endtask

  logic [ROWS-1:0] prev_row = '1;
  bit              stall_prev = 1'b0;
  logic [KW-1:0]   stall_code;
  logic            stall_rel;

  // Monitor on the falling edge: frame tracking, hold stability and the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_row   = '1;
      stall_prev = 1'b0;
    end else begin
      if (row_o == ROW0 && prev_row != ROW0) frame_start();
      prev_row = row_o;
      if (stall_prev) begin
        check("hold_valid", 32'(key_valid_o), 32'd1);
        check("hold_code", 32'(key_code_o), 32'(stall_code));
        check("hold_rel", 32'(key_release_o), 32'(stall_rel));
      end
      if (key_valid_o && key_ready_i) begin
        n_xfer++;
        last_code = int'(key_code_o);
        last_rel  = int'(key_release_o);
        check("event_expected", 32'(q_code.size() != 0), 32'd1);
        if (q_code.size() != 0) begin
          check("event_code", 32'(key_code_o), 32'(q_code.pop_front()));
          check("event_rel", 32'(key_release_o), 32'(q_rel.pop_front()));
        end
      end
      stall_prev = key_valid_o && !key_ready_i;
      stall_code = key_code_o;
      stall_rel  = key_release_o;
    end
  end

  task automatic wait_frames(input int n);
    int target;
    target = frame_cnt + n;
    for (int i = 0; i < (n + 2) * FRAME * 2 && frame_cnt < target; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("frame_timeout", 32'(frame_cnt >= target), 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10 * FRAME && !key_valid_o; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("valid_timeout", 32'(key_valid_o), 32'd1);
  endtask

  int            base;
  logic [ROWS-1:0] held_row;

  initial begin
    rst_ni      = 1'b0;
    key_ready_i = 1'b1;
    matrix      = '0;
    plan        = '0;
    mode        = 0;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_row", 32'(row_o), 32'hF);
    check("rst_valid", 32'(key_valid_o), 32'd0);
    check("rst_code", 32'(key_code_o), 32'd0);
    check("rst_state", 32'(key_state_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("row0_after_rst", 32'(row_o), 32'(ROW0));

    // Press key 6 and hold.
    plan = NK'(16'h0040);
    base = n_xfer;
    wait_frames(6);
    check("press6_count", 32'(n_xfer - base), 32'd1);
    check("press6_code", 32'(last_code), 32'd6);
    check("press6_rel", 32'(last_rel), 32'd0);
    check("press6_state", 32'(key_state_o[6]), 32'd1);

    // Bounce: key 6 alternates every frame, never reaching the debounce count.
    mode = 2;
    base = n_xfer;
    wait_frames(10);
    mode = 0;
    check("bounce_count", 32'(n_xfer - base), 32'd0);
    check("bounce_state", 32'(key_state_o[6]), 32'd1);

    // Backpressure: keys 0 and 1 flip together while the consumer is not ready.
    key_ready_i = 1'b0;
    plan        = NK'(16'h0043);
    base        = n_xfer;
    wait_valid();
    repeat (3) @(posedge clk_i);
    #1;
    check("bp_code", 32'(key_code_o), 32'd0);
    held_row = row_o;
    repeat (40) @(posedge clk_i);
    #1;
    check("bp_row_held", 32'(row_o), 32'(held_row));
    check("bp_row0", 32'(row_o), 32'(ROW0));
    check("bp_valid", 32'(key_valid_o), 32'd1);
    key_ready_i = 1'b1;
    wait_frames(3);
    check("bp_count", 32'(n_xfer - base), 32'd2);
    check("bp_last_code", 32'(last_code), 32'd1);

    // Release key 6.
    plan = NK'(16'h0003);
    base = n_xfer;
    wait_frames(6);
    check("rel6_count", 32'(n_xfer - base), 32'(REL_EN));
    check("rel6_code", 32'(last_code), REL_EN ? 32'd6 : 32'd1);
    check("rel6_rel", 32'(last_rel), 32'(REL_EN));
    check("rel6_state", 32'(key_state_o[6]), 32'd0);

    // Random matrix every frame with random consumer stalls.
    mode = 1;
    for (int i = 0; i < 25 * FRAME; i++) begin
      @(posedge clk_i);
      #1;
      key_ready_i = ($urandom_range(0, 3) != 0);
    end
    mode        = 0;
    plan        = '0;
    key_ready_i = 1'b1;
    wait_frames(8);
    check("rand_drained", 32'(q_code.size()), 32'd0);
    check("rand_state", 32'(key_state_o), 32'd0);

    // Reset while an event is held in the output slot.
    key_ready_i = 1'b0;
    plan        = NK'(16'h0020);
    wait_valid();
    rst_ni = 1'b0;
    plan   = '0;
    #1;
    check("mid_rst_valid", 32'(key_valid_o), 32'd0);
    check("mid_rst_row", 32'(row_o), 32'hF);
    check("mid_rst_state", 32'(key_state_o), 32'd0);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    key_ready_i = 1'b1;
    base        = n_xfer;
    @(posedge clk_i);
    #1;
    check("restart_row0", 32'(row_o), 32'(ROW0));
    wait_frames(6);
    check("no_stale_count", 32'(n_xfer - base), 32'd0);
    check("no_stale_queue", 32'(q_code.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
